fmap_ram_2d: RTL

//  Multi-channel 2D feature-map buffer for the CNN datapath. It holds CHANNELS planes of HEIGHT x WIDTH words.
//  - Write port: independent.
//  - Random-access read port: 1-cycle latency.
//  - Scan engine: streams one whole plane in raster order over a valid/ready interface into the conv pipeline.

---
 rtl/fmap_ram_2d.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fmap_ram_2d.sv
// Multi-channel 2D feature-map buffer: random write/read ports plus a raster scan engine streaming one plane.
// Optional zero border on the scan stream when RAM_2D_ZPAD_EN is defined.
module fmap_ram_2d #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned HEIGHT   = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 1,
  localparam int unsigned HW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int unsigned WW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_ch,
  input  logic [HW-1:0]     wr_haddr,
  input  logic [WW-1:0]     wr_waddr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [CW-1:0]     rd_ch,
  input  logic [HW-1:0]     rd_haddr,
  input  logic [WW-1:0]     rd_waddr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  input  logic              scan_start,
  input  logic [CW-1:0]     scan_ch,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

`ifdef RAM_2D_ZPAD_EN
  localparam int unsigned SH = HEIGHT + 2;
  localparam int unsigned SW = WIDTH + 2;
`else
  localparam int unsigned SH = HEIGHT;
  localparam int unsigned SW = WIDTH;
`endif
  localparam int unsigned RW    = (SH > 1) ? $clog2(SH) : 1;
  localparam int unsigned CLW   = (SW > 1) ? $clog2(SW) : 1;
  localparam int unsigned DEPTH = CHANNELS * HEIGHT * WIDTH;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  logic [DWIDTH-1:0] mem [DEPTH];

  state_t            state, next_state;
  logic [RW-1:0]     row;
  logic [CLW-1:0]    col;
  logic [CW-1:0]     ch;
  logic              issue, pop, scan_end, scan_zero, border;
  int unsigned       irow, icol;
  logic [AW-1:0]     wr_idx, rd_idx, scan_idx;
  logic              wr_ok, rd_ok;

  logic [DWIDTH-1:0] fdata [2];
  logic [1:0]        flast;
  logic [1:0]        count;
  logic              head, tail;

  assign wr_ok  = (32'(wr_ch) < CHANNELS) && (32'(wr_haddr) < HEIGHT) && (32'(wr_waddr) < WIDTH);
  assign rd_ok  = (32'(rd_ch) < CHANNELS) && (32'(rd_haddr) < HEIGHT) && (32'(rd_waddr) < WIDTH);
  assign wr_idx = AW'((32'(wr_ch) * HEIGHT + 32'(wr_haddr)) * WIDTH + 32'(wr_waddr));
  assign rd_idx = AW'((32'(rd_ch) * HEIGHT + 32'(rd_haddr)) * WIDTH + 32'(rd_waddr));

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_idx] <= wr_data;
  end

  always_comb begin
`ifdef RAM_2D_ZPAD_EN
    border = (row == '0) || (32'(row) == SH - 1) || (col == '0) || (32'(col) == SW - 1);
    irow   = 32'(row) - 1;
    icol   = 32'(col) - 1;
`else
    border = 1'b0;
    irow   = 32'(row);
    icol   = 32'(col);
`endif
    scan_zero = border || (32'(ch) >= CHANNELS);
    scan_idx  = AW'((32'(ch) * HEIGHT + irow) * WIDTH + icol);
    scan_end  = (32'(row) == SH - 1) && (32'(col) == SW - 1);
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = fdata[head];
  assign out_last  = flast[head] & out_valid;
  assign pop       = out_valid & out_ready;
  assign tail      = head ^ count[0];
  assign scan_busy = (state != IDLE);

  // A read is issued only when the 2-entry skid stage has a slot after this cycle's pop.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      IDLE:    if (scan_start) next_state = RUN;
      RUN: begin
        issue = (count < 2'd2) || pop;
        if (issue && scan_end) next_state = DRAIN;
      end
      DRAIN:   if (pop && flast[head]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      ch        <= '0;
      scan_done <= 1'b0;
      count     <= '0;
      head      <= 1'b0;
      flast     <= '0;
      for (int unsigned i = 0; i < 2; i++) fdata[i] <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= next_state;
      scan_done <= (state == DRAIN) && (next_state == IDLE);
      if (state == IDLE && scan_start) begin
        ch  <= scan_ch;
        row <= '0;
        col <= '0;
      end
      if (issue) begin
        if (32'(col) == SW - 1) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        fdata[tail] <= scan_zero ? '0 : mem[scan_idx];
        flast[tail] <= scan_end;
      end
      if (pop) head <= ~head;
      count <= count + 2'(issue) - 2'(pop);

      rd_valid <= rd_en && !scan_busy;
      if (rd_en && !scan_busy) rd_data <= rd_ok ? mem[rd_idx] : '0;
    end
  end

endmodule
